// File: rtl/filter_stream_if.sv
// Streaming bus between the sample sequencer, sample ROM, rank-order filter and result RAM.
interface filter_stream_if #(
  parameter int data_bits = 8,
  parameter int addr_bits = 8
);
  logic                 start;
  logic                 hold;
  logic [addr_bits-1:0] rom_addr;
  logic [data_bits-1:0] rom_data;
  logic                 filt_clr;
  logic                 sample_en;
  logic [data_bits-1:0] sample;
  logic [data_bits-1:0] filt_out;
  logic                 ram_wr_en;
  logic [addr_bits-1:0] ram_wr_addr;
  logic [data_bits-1:0] ram_wr_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, hold, rom_data, filt_out,
    input  rom_addr, filt_clr, sample_en, sample, ram_wr_en, ram_wr_addr, ram_wr_data, busy, done
  );

  modport slave (
    input  start, hold, rom_data, filt_out,
    output rom_addr, filt_clr, sample_en, sample, ram_wr_en, ram_wr_addr, ram_wr_data, busy, done
  );
endinterface

// File: rtl/filter_stream_ctrl.sv
// Single-clock sample sequencer: walks the sample ROM, strobes the filter and writes results to RAM.
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing ROM addresses (stalled by hold)
// DRAIN | all addresses issued, waiting for the last result write
// DONE  | run complete, waiting for a new start
module filter_stream_ctrl #(
  parameter int data_bits   = 8,
  parameter int addr_bits   = 8,
  parameter int NUM_SAMPLES = 255,
  parameter int ROM_LAT     = 1,
  parameter int FILT_LAT    = 1
) (
  input logic            clk,
  input logic            rst,
  filter_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [addr_bits-1:0] LAST = addr_bits'(NUM_SAMPLES - 1);

  state_t               state, state_nxt;
  logic [addr_bits-1:0] issue_cnt, wr_cnt;
  logic [ROM_LAT-1:0]   rom_vld;
  logic [FILT_LAT-1:0]  filt_vld;
  logic                 filt_clr_q;
  logic                 launch, issue, last_issue, last_write;
  logic                 busy_c, done_c;

  assign launch     = ((state == IDLE) || (state == DONE)) && bus.start;
  assign issue      = (state == RUN) && !bus.hold;
  assign last_issue = issue && (issue_cnt == LAST);
  assign last_write = bus.ram_wr_en && (wr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (last_write) state_nxt = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters stop on their final address so they never wrap, even when NUM_SAMPLES fills the address space.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt  <= '0;
      wr_cnt     <= '0;
      rom_vld    <= '0;
      filt_vld   <= '0;
      filt_clr_q <= 1'b0;
    end else begin
      filt_clr_q <= launch;
      rom_vld    <= (rom_vld << 1) | ROM_LAT'(issue);
      filt_vld   <= (filt_vld << 1) | FILT_LAT'(rom_vld[ROM_LAT-1]);
      if (launch) begin
        issue_cnt <= '0;
        wr_cnt    <= '0;
      end else begin
        if (issue && !last_issue)        issue_cnt <= issue_cnt + 1'b1;
        if (bus.ram_wr_en && !last_write) wr_cnt    <= wr_cnt + 1'b1;
      end
    end
  end

  assign bus.rom_addr    = issue_cnt;
  assign bus.filt_clr    = filt_clr_q;
  assign bus.sample_en   = rom_vld[ROM_LAT-1];
  assign bus.sample      = data_bits'(bus.rom_data);
  assign bus.ram_wr_en   = filt_vld[FILT_LAT-1];
  assign bus.ram_wr_addr = wr_cnt;
  assign bus.ram_wr_data = bus.filt_out;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;

endmodule
